ipsl_pcie_dma_mwr_tlp_gen: RTL and testbench

//  Builds posted Memory Write TLPs for the DMA engine. It takes one write request (address, length, ID, tag) and pulls
//  DW-aligned 128-bit payload beats from the DMA read-control stage through its tlp_tx/tx_hold pull interface.
//  It emits header+payload as a 128-bit valid/ready stream to the PCIe core TX port. Sits directly downstream of the read-control stage.

---
 rtl/ipsl_pcie_dma_mwr_tlp_gen.sv | 270 +++++++++++++++++++++++++++
 tb/tb_ipsl_pcie_dma_mwr_tlp_gen.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsl_pcie_dma_mwr_tlp_gen.sv
// ----------------------------------------------------------------------------
// ipsl_pcie_dma_mwr_tlp_gen
//
// Builds posted Memory Write TLPs for the DMA engine. A single write request
// (address, length, requester ID, tag) is accepted in IDLE. DW-aligned 128-bit
// payload beats are then pulled from the read-control stage through the
// o_tlp_tx / o_tx_hold interface. Header and payload go out as a 128-bit
// valid/ready stream through a single output register slot.
//
// Ports
//   clk, rst_n         core user clock, asynchronous active-low reset
//   i_tx_restart       synchronous abort of the TLP in flight (clears o_len_err)
//   i_mwr_req ...      request strobe + address/length/ID/tag (sampled in IDLE)
//   o_busy             request accepted, TLP not yet fully sent
//   o_mwr_done         one-cycle pulse on the final output beat handshake
//   o_len_err          sticky length / last-beat-flag error
//   i_gen_tlp_start,
//   i_rd_data,
//   i_last_data        upstream payload beat (valid, data, last flag)
//   o_tlp_tx, o_tx_hold  upstream pull control; pop = valid & tlp_tx & ~hold
//   o_tx_t*            TX stream to the PCIe core
//
// Configuration macro
//   IPSL_PCIE_MWR_FORCE_4DW_EN  defined: every TLP uses a 4DW header.
//                               undefined: 4DW only when addr[63:32] != 0.
// ----------------------------------------------------------------------------
module ipsl_pcie_dma_mwr_tlp_gen #(
    parameter logic [10:0] MAX_LEN_DW = 11'd256,
    parameter logic [2:0]  TLP_TC     = 3'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_tx_restart,
    input  logic         i_mwr_req,
    input  logic [63:0]  i_mwr_addr,
    input  logic [9:0]   i_mwr_length,
    input  logic [15:0]  i_req_id,
    input  logic [7:0]   i_tag,
    output logic         o_busy,
    output logic         o_mwr_done,
    output logic         o_len_err,
    input  logic         i_gen_tlp_start,
    input  logic [127:0] i_rd_data,
    input  logic         i_last_data,
    output logic         o_tlp_tx,
    output logic         o_tx_hold,
    output logic         o_tx_tvalid,
    input  logic         i_tx_tready,
    output logic [127:0] o_tx_tdata,
    output logic [3:0]   o_tx_tkeep,
    output logic         o_tx_tlast
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_TAIL, S_DONE} state_t;

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           len_err_q, len_err_d;
    logic           four_dw_q, four_dw_d;
    logic [9:0]     len_q, len_d;
    logic [63:0]    addr_q, addr_d;
    logic [15:0]    req_id_q, req_id_d;
    logic [7:0]     tag_q, tag_d;
    logic [10:0]    rem_dw_q, rem_dw_d;
    logic [7:0]     beats_left_q, beats_left_d;   // upstream beats still to pop
    logic [95:0]    carry_q, carry_d;             // upper 3 DW held back in 3DW mode
    logic           tvalid_q, tvalid_d;
    logic [127:0]   tdata_q, tdata_d;
    logic [3:0]     tkeep_q, tkeep_d;
    logic           tlast_q, tlast_d;

    logic           out_rdy, tlp_tx, pop, last_pop, len_ok, req_four_dw;
    logic [2:0]     n_dw;
    logic [10:0]    rem_after;
    logic [31:0]    dw0, dw1, addr_lo;

    function automatic logic [3:0] keep_of(input logic [2:0] n);
        case (n)
            3'd1:    keep_of = 4'h1;
            3'd2:    keep_of = 4'h3;
            3'd3:    keep_of = 4'h7;
            3'd4:    keep_of = 4'hF;
            default: keep_of = 4'h0;
        endcase
    endfunction

`ifdef IPSL_PCIE_MWR_FORCE_4DW_EN
    assign req_four_dw = 1'b1;
`else
    assign req_four_dw = |i_mwr_addr[63:32];
`endif

    assign out_rdy   = ~tvalid_q | i_tx_tready;
    assign tlp_tx    = ((state_q == S_HDR) & ~four_dw_q) | (state_q == S_DATA);
    // Hold is also asserted outside the payload phase so upstream never sees
    // an open pull window while idle or in reset.
    assign o_tx_hold = ~(tlp_tx & out_rdy);
    assign pop       = i_gen_tlp_start & tlp_tx & out_rdy;
    assign last_pop  = (beats_left_q == 8'd1);
    assign len_ok    = (i_mwr_length != 10'd0) && ({1'b0, i_mwr_length} <= MAX_LEN_DW);
    assign n_dw      = (rem_dw_q >= 11'd4) ? 3'd4 : rem_dw_q[2:0];
    assign rem_after = rem_dw_q - {8'd0, n_dw};

    // Masking keeps the ignored address bits out of the header.
    assign addr_lo = addr_q[31:0] & 32'hFFFF_FFFC;
    assign dw0     = {(four_dw_q ? 3'b011 : 3'b010), 5'b0, 1'b0, TLP_TC, 4'b0,
                      1'b0, 1'b0, 2'b00, 2'b00, len_q};
    assign dw1     = {req_id_q, tag_q, ((len_q == 10'd1) ? 4'h0 : 4'hF), 4'hF};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_mwr_req && len_ok) state_d = S_HDR;
            S_HDR: begin
                if (four_dw_q) begin
                    // Header waits for payload so the link never stalls mid-TLP.
                    if (i_gen_tlp_start && out_rdy) state_d = S_DATA;
                end else if (pop) begin
                    if (last_pop) state_d = (rem_dw_q == 11'd1) ? S_DONE : S_TAIL;
                    else          state_d = S_DATA;
                end
            end
            S_DATA: if (pop && last_pop)
                        state_d = (!four_dw_q && rem_after != 11'd0) ? S_TAIL : S_DONE;
            S_TAIL: if (out_rdy) state_d = S_DONE;
            S_DONE: if (tvalid_q && i_tx_tready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_tx_restart) state_d = S_IDLE;
    end

    // Datapath / output logic
    always_comb begin
        busy_d       = busy_q;
        len_err_d    = len_err_q;
        four_dw_d    = four_dw_q;
        len_d        = len_q;
        addr_d       = addr_q;
        req_id_d     = req_id_q;
        tag_d        = tag_q;
        rem_dw_d     = rem_dw_q;
        beats_left_d = beats_left_q;
        carry_d      = carry_q;
        tvalid_d     = tvalid_q & ~i_tx_tready;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tlast_d      = tlast_q;

        case (state_q)
            S_IDLE: begin
                if (i_mwr_req) begin
                    if (len_ok) begin
                        busy_d       = 1'b1;
                        four_dw_d    = req_four_dw;
                        len_d        = i_mwr_length;
                        addr_d       = i_mwr_addr;
                        req_id_d     = i_req_id;
                        tag_d        = i_tag;
                        rem_dw_d     = {1'b0, i_mwr_length};
                        beats_left_d = 8'(({1'b0, i_mwr_length} + 11'd3) >> 2);
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            S_HDR: begin
                if (four_dw_q) begin
                    if (i_gen_tlp_start && out_rdy) begin
                        tvalid_d = 1'b1;
                        tdata_d  = {addr_lo, addr_q[63:32], dw1, dw0};
                        tkeep_d  = 4'hF;
                        tlast_d  = 1'b0;
                    end
                end else if (pop) begin
                    tvalid_d     = 1'b1;
                    tdata_d      = {i_rd_data[31:0], addr_lo, dw1, dw0};
                    tkeep_d      = 4'hF;
                    tlast_d      = (rem_dw_q == 11'd1);
                    carry_d      = i_rd_data[127:32];
                    rem_dw_d     = rem_dw_q - 11'd1;
                    beats_left_d = beats_left_q - 8'd1;
                    if (i_last_data != last_pop) len_err_d = 1'b1;
                end
            end
            S_DATA: begin
                if (pop) begin
                    tvalid_d     = 1'b1;
                    tdata_d      = four_dw_q ? i_rd_data : {i_rd_data[31:0], carry_q};
                    tkeep_d      = keep_of(n_dw);
                    tlast_d      = (rem_after == 11'd0);
                    carry_d      = i_rd_data[127:32];
                    rem_dw_d     = rem_after;
                    beats_left_d = beats_left_q - 8'd1;
                    if (i_last_data != last_pop) len_err_d = 1'b1;
                end
            end
            S_TAIL: begin
                if (out_rdy) begin
                    tvalid_d = 1'b1;
                    tdata_d  = {32'b0, carry_q};
                    tkeep_d  = keep_of(rem_dw_q[2:0]);
                    tlast_d  = 1'b1;
                    rem_dw_d = 11'd0;
                end
            end
            S_DONE: if (tvalid_q && i_tx_tready) busy_d = 1'b0;
            default: ;
        endcase

        if (i_tx_restart) begin
            busy_d       = 1'b0;
            len_err_d    = 1'b0;
            rem_dw_d     = 11'd0;
            beats_left_d = 8'd0;
            carry_d      = 96'd0;
            tvalid_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            len_err_q    <= 1'b0;
            four_dw_q    <= 1'b0;
            len_q        <= 10'd0;
            addr_q       <= 64'd0;
            req_id_q     <= 16'd0;
            tag_q        <= 8'd0;
            rem_dw_q     <= 11'd0;
            beats_left_q <= 8'd0;
            carry_q      <= 96'd0;
            tvalid_q     <= 1'b0;
            tdata_q      <= 128'd0;
            tkeep_q      <= 4'h0;
            tlast_q      <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            len_err_q    <= len_err_d;
            four_dw_q    <= four_dw_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            req_id_q     <= req_id_d;
            tag_q        <= tag_d;
            rem_dw_q     <= rem_dw_d;
            beats_left_q <= beats_left_d;
            carry_q      <= carry_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_len_err   = len_err_q;
    assign o_tlp_tx    = tlp_tx;
    assign o_mwr_done  = (state_q == S_DONE) & tvalid_q & i_tx_tready & ~i_tx_restart;
    assign o_tx_tvalid = tvalid_q;
    assign o_tx_tdata  = tdata_q;
    assign o_tx_tkeep  = tkeep_q;
    assign o_tx_tlast  = tlast_q;

endmodule

// File: tb/tb_ipsl_pcie_dma_mwr_tlp_gen.sv
module tb_ipsl_pcie_dma_mwr_tlp_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_tx_restart;
    logic         i_mwr_req;
    logic [63:0]  i_mwr_addr;
    logic [9:0]   i_mwr_length;
    logic [15:0]  i_req_id;
    logic [7:0]   i_tag;
    logic         o_busy, o_mwr_done, o_len_err;
    logic         i_gen_tlp_start;
    logic [127:0] i_rd_data;
    logic         i_last_data;
    logic         o_tlp_tx, o_tx_hold, o_tx_tvalid;
    logic         i_tx_tready;
    logic [127:0] o_tx_tdata;
    logic [3:0]   o_tx_tkeep;
    logic         o_tx_tlast;

    always #5 clk = ~clk;

    ipsl_pcie_dma_mwr_tlp_gen dut (
        .clk(clk), .rst_n(rst_n), .i_tx_restart(i_tx_restart),
        .i_mwr_req(i_mwr_req), .i_mwr_addr(i_mwr_addr), .i_mwr_length(i_mwr_length),
        .i_req_id(i_req_id), .i_tag(i_tag),
        .o_busy(o_busy), .o_mwr_done(o_mwr_done), .o_len_err(o_len_err),
        .i_gen_tlp_start(i_gen_tlp_start), .i_rd_data(i_rd_data), .i_last_data(i_last_data),
        .o_tlp_tx(o_tlp_tx), .o_tx_hold(o_tx_hold), .o_tx_tvalid(o_tx_tvalid),
        .i_tx_tready(i_tx_tready), .o_tx_tdata(o_tx_tdata), .o_tx_tkeep(o_tx_tkeep),
        .o_tx_tlast(o_tx_tlast)
    );

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_data_q[$];
    logic [3:0]   exp_keep_q[$];
    logic         exp_last_q[$];
    logic [128:0] src_q[$];          // {last_flag, beat}
    int ready_mode = 0;              // 0: always ready, 1: toggle, 2: random
    bit ignore_beats = 1'b0;
    int beats_seen = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: header DWs followed by payload DWs, cut into 4-DW beats.
    task automatic push_expected(input logic [63:0] addr, input int len,
                                 input logic [15:0] rid, input logic [7:0] tag,
                                 input logic [31:0] pay[$]);
        logic [31:0] w[$];
        bit four;
        logic [9:0] l10;
        l10 = 10'(len);
`ifdef IPSL_PCIE_MWR_FORCE_4DW_EN
        four = 1'b1;
`else
        four = (addr[63:32] != 32'd0);
`endif
        w.push_back({(four ? 3'b011 : 3'b010), 19'd0, l10});
        w.push_back({rid, tag, ((len == 1) ? 4'h0 : 4'hF), 4'hF});
        if (four) w.push_back(addr[63:32]);
        w.push_back({addr[31:2], 2'b00});
        foreach (pay[i]) w.push_back(pay[i]);
        for (int b = 0; b < w.size(); b += 4) begin
            logic [127:0] d;
            logic [3:0]   k;
            d = '0;
            k = '0;
            for (int l = 0; l < 4; l++) begin
                if (b + l < w.size()) begin
                    d[32*l +: 32] = w[b + l];
                    k[l] = 1'b1;
                end
            end
            exp_data_q.push_back(d);
            exp_keep_q.push_back(k);
            exp_last_q.push_back(b + 4 >= w.size());
        end
    endtask

    // Upstream payload source
    initial begin
        bit pend;
        i_gen_tlp_start = 1'b0;
        i_rd_data = '0;
        i_last_data = 1'b0;
        forever begin
            @(negedge clk);
            pend = i_gen_tlp_start & o_tlp_tx & ~o_tx_hold;
            @(posedge clk);
            #1;
            if (pend && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                i_gen_tlp_start = 1'b1;
                i_rd_data = src_q[0][127:0];
                i_last_data = src_q[0][128];
            end else begin
                i_gen_tlp_start = 1'b0;
                i_rd_data = {$urandom, $urandom, $urandom, $urandom};
                i_last_data = 1'b0;
            end
        end
    end

    // TX ready driver
    initial begin
        i_tx_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: i_tx_tready = 1'b1;
                1: i_tx_tready = ~i_tx_tready;
                default: i_tx_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_tlp_tx) check("tx_hold", 128'(o_tx_hold), 128'(o_tx_tvalid & ~i_tx_tready));
            if (o_tx_tvalid && i_tx_tready) begin
                beats_seen++;
                if (!ignore_beats) begin
                    if (exp_data_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%h required=none", o_tx_tdata);
                    end else begin
                        logic [127:0] ed, mask;
                        logic [3:0] ek;
                        logic el;
                        ed = exp_data_q.pop_front();
                        ek = exp_keep_q.pop_front();
                        el = exp_last_q.pop_front();
                        mask = '0;
                        for (int l = 0; l < 4; l++) if (ek[l]) mask[32*l +: 32] = '1;
                        check("tdata", o_tx_tdata & mask, ed);
                        check("tkeep", 128'(o_tx_tkeep), 128'(ek));
                        check("tlast", 128'(o_tx_tlast), 128'(el));
                    end
                end
            end
            if (o_mwr_done) begin
                done_cnt++;
                check("done_on_last_beat", 128'(o_tx_tvalid & i_tx_tready & o_tx_tlast), 128'd1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_wait", 128'(o_busy), 128'd0);
    endtask

    task automatic issue_req(input logic [63:0] addr, input int len);
        i_mwr_addr = addr;
        i_mwr_length = 10'(len);
        i_req_id = 16'($urandom);
        i_tag = 8'($urandom);
        i_mwr_req = 1'b1;
        @(posedge clk);
        #1;
        i_mwr_req = 1'b0;
    endtask

    task automatic pulse_restart();
        i_tx_restart = 1'b1;
        @(posedge clk);
        #1;
        i_tx_restart = 1'b0;
    endtask

    task automatic run_mwr(input logic [63:0] addr, input int len, input bit bad_last);
        logic [31:0] pay[$];
        int nb, d0, n;
        wait_idle();
        nb = (len + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            logic [127:0] beat;
            bit lf;
            beat = {$urandom, $urandom, $urandom, $urandom};
            lf = bad_last ? (b == 0) : (b == nb - 1);
            src_q.push_back({lf, beat});
            for (int l = 0; l < 4; l++) if (b * 4 + l < len) pay.push_back(beat[32*l +: 32]);
        end
        i_mwr_addr = addr;
        i_mwr_length = 10'(len);
        i_req_id = 16'($urandom);
        i_tag = 8'($urandom);
        push_expected(addr, len, i_req_id, i_tag, pay);
        d0 = done_cnt;
        i_mwr_req = 1'b1;
        @(posedge clk);
        #1;
        i_mwr_req = 1'b0;
        check("busy_after_req", 128'(o_busy), 128'd1);
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("done_count", 128'(done_cnt), 128'(d0 + 1));
        check("sb_empty", 128'(exp_data_q.size()), 128'd0);
        check("src_drained", 128'(src_q.size()), 128'd0);
        check("busy_after_done", 128'(o_busy), 128'd0);
        check("len_err_flag", 128'(o_len_err), 128'(bad_last));
        $display("txn addr=%h len=%0d ready_mode=%0d bad_last=%0d", addr, len, ready_mode, bad_last);
        exp_data_q.delete();
        exp_keep_q.delete();
        exp_last_q.delete();
        src_q.delete();
    endtask

    task automatic bad_len(input int len);
        int b0;
        wait_idle();
        b0 = beats_seen;
        issue_req(64'h1000, len);
        repeat (5) @(posedge clk);
        #1;
        check("len_err_set", 128'(o_len_err), 128'd1);
        check("len_err_busy", 128'(o_busy), 128'd0);
        check("len_err_no_beats", 128'(beats_seen), 128'(b0));
        pulse_restart();
        check("len_err_cleared", 128'(o_len_err), 128'd0);
        $display("txn bad_len len=%0d", len);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i_tx_restart = 1'b0;
        i_mwr_req = 1'b0;
        i_mwr_addr = '0;
        i_mwr_length = '0;
        i_req_id = '0;
        i_tag = '0;
        #1;
        check("rst_tvalid", 128'(o_tx_tvalid), 128'd0);
        check("rst_busy", 128'(o_busy), 128'd0);
        check("rst_done", 128'(o_mwr_done), 128'd0);
        check("rst_len_err", 128'(o_len_err), 128'd0);
        check("rst_tlp_tx", 128'(o_tlp_tx), 128'd0);
        check("rst_tx_hold", 128'(o_tx_hold), 128'd1);
        check("rst_tdata", o_tx_tdata, 128'd0);
        check("rst_tkeep_tlast", 128'({o_tx_tkeep, o_tx_tlast}), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        ready_mode = 0;
        run_mwr(64'h1_0000_0000, 8, 1'b0);
        run_mwr(64'h1000, 6, 1'b0);
        run_mwr(64'h1000, 1, 1'b0);
        ready_mode = 1;
        run_mwr(64'h1000, 4, 1'b0);
        ready_mode = 0;
        run_mwr(64'h1000, 5, 1'b0);
        run_mwr(64'h2_0000_1004, 2, 1'b0);

        bad_len(0);
        bad_len(257);

        run_mwr(64'h3000, 8, 1'b1);
        pulse_restart();
        check("last_err_cleared", 128'(o_len_err), 128'd0);

        // Abort a TLP in the middle of its payload.
        begin
            int b0, d0, n;
            wait_idle();
            ignore_beats = 1'b1;
            for (int b = 0; b < 4; b++)
                src_q.push_back({(b == 3), $urandom, $urandom, $urandom, $urandom});
            b0 = beats_seen;
            d0 = done_cnt;
            issue_req(64'h1000, 16);
            n = 0;
            while (beats_seen < b0 + 2 && n < 500) begin
                @(posedge clk);
                n++;
            end
            #1;
            check("restart_reached_data", 128'(beats_seen >= b0 + 2), 128'd1);
            pulse_restart();
            check("restart_tvalid", 128'(o_tx_tvalid), 128'd0);
            check("restart_busy", 128'(o_busy), 128'd0);
            check("restart_no_done", 128'(done_cnt), 128'(d0));
            src_q.delete();
            ignore_beats = 1'b0;
            $display("txn restart_mid_data len=16");
        end
        run_mwr(64'h1000, 4, 1'b0);

        for (int t = 0; t < 25; t++) begin
            logic [63:0] a;
            int r, len;
            ready_mode = $urandom_range(0, 2);
            a = {($urandom_range(0, 1) != 0) ? $urandom : 32'd0, $urandom};
            r = $urandom_range(0, 9);
            len = (r == 0) ? 256 : (r == 1) ? $urandom_range(100, 255) : $urandom_range(1, 12);
            run_mwr(a, len, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
